ifetch_ctrl: RTL and testbench

- Fetch-stage controller directly downstream of the PC register.
- Consumes the current PC and issues requests to a variable-latency instruction memory using a valid/ready handshake.
- Captures each returned instruction into the IF/ID pipeline register, or into a one-entry hold buffer while ID is stalled.
- Drives the PC register's update enable, so the PC advances exactly once per instruction delivered to ID.

---
 rtl/ifetch_ctrl.sv | 128 ++++++++++++
 tb/tb_ifetch_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Fetch controller between the PC register and IF/ID.
// One request in flight; a one-entry hold buffer absorbs ID stalls.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_update,
  output logic        im_req_valid,
  output logic [31:0] im_req_addr,
  input  logic        im_req_ready,
  input  logic        im_resp_valid,
  input  logic [31:0] im_resp_data,
  input  logic        id_stall,
  input  logic        redirect,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        fetch_adel
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  logic        drop;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic accept;
  logic aligned;
  logic req_fire;
  logic resp_load;
  logic adel_load;
  logic hold_load;

  assign accept    = !id_stall || !id_valid;
  assign aligned   = (pc[1:0] == 2'b00);
  assign req_fire  = im_req_valid && im_req_ready;
  assign resp_load = (state == S_WAIT) && im_resp_valid
                   && !drop && accept;
  assign adel_load = (state == S_REQ) && !aligned && accept;
  assign hold_load = (state == S_HOLD) && !id_stall;

  assign im_req_valid = !reset && (state == S_REQ) && aligned;
  assign im_req_addr  = pc;
  assign id_pc8       = id_pc + 32'd8;

  assign pc_update = !reset && (redirect || resp_load
                   || adel_load || hold_load);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      drop       <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= RESET_PC;
      id_valid   <= 1'b0;
      id_instr   <= NOP_INSTR;
      id_pc      <= RESET_PC;
      fetch_adel <= 1'b0;
    end else if (redirect) begin
      id_valid   <= 1'b0;
      id_instr   <= NOP_INSTR;
      fetch_adel <= 1'b0;
      // An in-flight or just-accepted request must be swallowed.
      if (state == S_WAIT) begin
        if (im_resp_valid) begin
          state <= S_REQ;
          drop  <= 1'b0;
        end else begin
          drop  <= 1'b1;
        end
      end else begin
        state <= req_fire ? S_WAIT : S_REQ;
        drop  <= req_fire;
      end
    end else begin
      unique case (state)
        S_REQ: begin
          if (req_fire) begin
            state <= S_WAIT;
          end else if (adel_load) begin
            id_valid   <= 1'b1;
            id_instr   <= NOP_INSTR;
            id_pc      <= pc;
            fetch_adel <= 1'b1;
          end
        end
        S_WAIT: begin
          if (im_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else if (accept) begin
              id_valid   <= 1'b1;
              id_instr   <= im_resp_data;
              id_pc      <= pc;
              fetch_adel <= 1'b0;
              state      <= S_REQ;
            end else begin
              hold_instr <= im_resp_data;
              hold_pc    <= pc;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            id_valid   <= 1'b1;
            id_instr   <= hold_instr;
            id_pc      <= hold_pc;
            fetch_adel <= 1'b0;
            state      <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl with a small memory
// model and a PC register model.
`timescale 1ns/1ps
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_update;
  logic        im_req_valid;
  logic [31:0] im_req_addr;
  logic        im_req_ready;
  logic        im_resp_valid;
  logic [31:0] im_resp_data;
  logic        id_stall;
  logic        redirect;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        fetch_adel;

  ifetch_ctrl dut (
    .clk(clk), .reset(reset), .pc(pc),
    .pc_update(pc_update),
    .im_req_valid(im_req_valid),
    .im_req_addr(im_req_addr),
    .im_req_ready(im_req_ready),
    .im_resp_valid(im_resp_valid),
    .im_resp_data(im_resp_data),
    .id_stall(id_stall), .redirect(redirect),
    .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc8(id_pc8),
    .fetch_adel(fetch_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   upd_cnt = 0;
  int   cyc = 0;
  logic pend = 1'b0;

  int          lat = 1;
  int          cnt = 0;
  logic        fire_n = 1'b0;
  logic [31:0] faddr = '0;
  logic [31:0] maddr = '0;
  logic        upd_s = 1'b0;
  logic        red_s = 1'b0;
  logic        rst_s = 1'b0;
  logic [31:0] tgt = '0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h300C) return 32'h2401_0005;
    return a | 32'h1100_0000;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic push(input logic [31:0] p,
                      input logic [31:0] i,
                      input logic a);
    exp_t e;
    e.pc = p; e.instr = i; e.adel = a;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_upd(input int n, output int c);
    int k;
    k = 0;
    while (upd_cnt < n && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    chk("upd_wait", 32'(upd_cnt >= n), 32'd1);
    c = cyc;
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every IF/ID load is checked here.
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_load: id_pc %h", id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("ld_valid", 32'(id_valid), 32'd1);
        chk("ld_pc", id_pc, e.pc);
        chk("ld_pc8", id_pc8, e.pc + 32'd8);
        chk("ld_instr", id_instr, e.instr);
        chk("ld_adel", 32'(fetch_adel), 32'(e.adel));
      end
    end
    pend = pc_update && !redirect && !reset;
    if (pc_update && !reset) upd_cnt++;
  end

  // Memory: handshake sampled mid-cycle, data driven after the edge.
  always @(negedge clk) begin
    fire_n = im_req_valid && im_req_ready;
    faddr  = im_req_addr;
  end

  always @(posedge clk) begin
    #1;
    im_resp_valid = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        im_resp_valid = 1'b1;
        im_resp_data  = mem(maddr);
      end
    end
    if (fire_n) begin
      maddr = faddr;
      if (lat == 1) begin
        im_resp_valid = 1'b1;
        im_resp_data  = mem(maddr);
      end else begin
        cnt = lat - 1;
      end
    end
  end

  // PC register model.
  always @(negedge clk) begin
    upd_s = pc_update;
    red_s = redirect;
    rst_s = reset;
  end

  always @(posedge clk) begin
    #1;
    if (rst_s) pc = 32'h3000;
    else if (upd_s) pc = red_s ? tgt : pc + 32'd4;
  end

  initial begin
    int t1, t2, t3, tmp;
    reset = 1'b1;
    pc = 32'h3000;
    im_req_ready = 1'b1;
    im_resp_valid = 1'b0;
    im_resp_data = '0;
    id_stall = 1'b0;
    redirect = 1'b0;

    tick();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc", id_pc, 32'h3000);
    chk("rst_pc8", id_pc8, 32'h3008);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_adel", 32'(fetch_adel), 32'd0);
    chk("rst_req", 32'(im_req_valid), 32'd0);
    chk("rst_upd", 32'(pc_update), 32'd0);
    tick();

    // Zero-latency stream of three fetches.
    push(32'h3000, 32'h1100_3000, 1'b0);
    push(32'h3004, 32'h1100_3004, 1'b0);
    push(32'h3008, 32'h1100_3008, 1'b0);
    reset = 1'b0;
    wait_upd(1, t1);
    wait_upd(2, t2);
    wait_upd(3, t3);
    chk("gap12", 32'(t2 - t1), 32'd2);
    chk("gap23", 32'(t3 - t2), 32'd2);
    tick();

    // Response returns while ID is stalled.
    push(32'h300C, 32'h2401_0005, 1'b0);
    id_stall = 1'b1;
    repeat (4) tick();
    chk("hold_req", 32'(im_req_valid), 32'd0);
    chk("hold_instr", id_instr, 32'h1100_3008);
    chk("hold_upd", 32'(upd_cnt), 32'd3);
    id_stall = 1'b0;
    #1;
    chk("rel_upd", 32'(pc_update), 32'd1);
    tick();
    chk("rel_instr", id_instr, 32'h2401_0005);
    chk("rel_cnt", 32'(upd_cnt), 32'd4);
    im_req_ready = 1'b0;

    // Redirect while waiting on a slow response.
    lat = 3;
    im_req_ready = 1'b1;
    tick();
    redirect = 1'b1;
    tgt = 32'h4180;
    #1;
    chk("redir_upd", 32'(pc_update), 32'd1);
    tick();
    redirect = 1'b0;
    chk("redir_valid", 32'(id_valid), 32'd0);
    chk("redir_instr", id_instr, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (im_req_valid) break;
      tick();
    end
    chk("redir_req", 32'(im_req_valid), 32'd1);
    chk("redir_addr", im_req_addr, 32'h4180);
    chk("drop_valid", 32'(id_valid), 32'd0);
    push(32'h4180, 32'h1100_4180, 1'b0);
    wait_upd(6, tmp);
    tick();
    im_req_ready = 1'b0;
    lat = 1;

    // Misaligned PC.
    pc = 32'h3002;
    push(32'h3002, 32'h0, 1'b1);
    #1;
    chk("mis_req", 32'(im_req_valid), 32'd0);
    chk("mis_upd", 32'(pc_update), 32'd1);
    tick();
    id_stall = 1'b1;
    #1;
    chk("mis_req2", 32'(im_req_valid), 32'd0);
    tick();
    chk("mis_cnt", 32'(upd_cnt), 32'd7);
    chk("mis_keep", id_pc, 32'h3002);

    // Reset in the middle of WAIT, stale response afterwards.
    pc = 32'h3000;
    id_stall = 1'b0;
    lat = 3;
    im_req_ready = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    chk("rw_upd", 32'(pc_update), 32'd0);
    chk("rw_req", 32'(im_req_valid), 32'd0);
    tick();
    reset = 1'b0;
    im_req_ready = 1'b0;
    #1;
    chk("rw_valid", 32'(id_valid), 32'd0);
    chk("rw_pc", id_pc, 32'h3000);
    chk("rw_adel", 32'(fetch_adel), 32'd0);
    chk("rw_upd2", 32'(pc_update), 32'd0);
    tick();
    tick();
    chk("stale_valid", 32'(id_valid), 32'd0);
    chk("stale_cnt", 32'(upd_cnt), 32'd7);
    chk("stale_req", 32'(im_req_valid), 32'd1);
    lat = 1;
    im_req_ready = 1'b1;
    push(32'h3000, 32'h1100_3000, 1'b0);
    wait_upd(8, tmp);
    tick();
    im_req_ready = 1'b0;

    // Memory not ready for five cycles.
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("nr_req", 32'(im_req_valid), 32'd1);
      chk("nr_addr", im_req_addr, 32'h3004);
      chk("nr_upd", 32'(pc_update), 32'd0);
      tick();
    end
    im_req_ready = 1'b1;
    push(32'h3004, 32'h1100_3004, 1'b0);
    wait_upd(9, tmp);
    tick();
    im_req_ready = 1'b0;
    tick();
    tick();
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    chk("upd_total", 32'(upd_cnt), 32'd9);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
